mult_iter: RTL and testbench

MULT_ITER -- requirements
Module: mult_iter

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_pp_row.sv | 23 ++
 rtl/mult_iter.sv | 94 +++++++++
 tb/tb_mult_iter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and width helpers for the iterative shift-add multiplier.
// The state type is shared so checkers bound to the debug port decode it consistently.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full-precision width of a signed (a_w+1)-bit by unsigned b_w-bit product.
    function automatic int prod_w(input int a_w, input int b_w);
        return a_w + b_w + 1;
    endfunction

    // Width of the iteration index, which counts 0 .. b_w-1.
    function automatic int idx_w(input int b_w);
        return (b_w > 1) ? $clog2(b_w) : 1;
    endfunction

endpackage

// File: rtl/mult_pp_row.sv
// One partial-product row: the signed operand sign-extended to product width
// and shifted left by the current iteration index.
module mult_pp_row
    import mult_pkg::*;
#(
    parameter int A_W = 8,
    parameter int B_W = 8,
    localparam int P_W = prod_w(A_W, B_W),
    localparam int IDX_W = idx_w(B_W)
) (
    input  logic [A_W:0]     a_s,
    input  logic [IDX_W-1:0] idx,
    output logic [P_W-1:0]   row
);

    logic [P_W-1:0] a_ext;

    always_comb begin
        a_ext = {{B_W{a_s[A_W]}}, a_s};
        row   = a_ext << idx;
    end

endmodule

// File: rtl/mult_iter.sv
// Iterative signed-by-unsigned multiplier: one b bit per BUSY cycle, stopping
// as soon as the remaining b bits are all zero.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
// the sender holds its payload until that edge, and ready never depends on valid.
module mult_iter
    import mult_pkg::*;
#(
    parameter int A_W = 8,
    parameter int B_W = 8,
    localparam int P_W = prod_w(A_W, B_W),
    localparam int IDX_W = idx_w(B_W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           as,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] mul,
    output logic [1:0]     dbg_state
);

    state_t           state;
    logic [A_W:0]     a_reg;
    logic [B_W-1:0]   b_reg;
    logic [B_W-1:0]   b_shift;
    logic [IDX_W-1:0] idx;
    logic [P_W-1:0]   acc;
    logic [P_W-1:0]   acc_next;
    logic [P_W-1:0]   row;

    mult_pp_row #(
        .A_W(A_W),
        .B_W(B_W)
    ) u_pp_row (
        .a_s(a_reg),
        .idx(idx),
        .row(row)
    );

    always_comb begin
        b_shift  = b_reg >> 1;
        acc_next = b_reg[0] ? (acc + row) : acc;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    // mul is a separate register so the previous product survives the
    // accumulator being cleared when the next operand set is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            acc   <= '0;
            mul   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= {as, a};
                        b_reg <= b;
                        idx   <= '0;
                        acc   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    b_reg <= b_shift;
                    idx   <= idx + IDX_W'(1);
                    if (b_shift == '0) begin
                        mul   <= acc_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_iter.sv
// Bench for mult_iter: directed corner cases on an 8x8 and a 2x2 instance,
// then randomized traffic against an arithmetic reference model.
module tb_mult_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sa;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] mul;
    logic [1:0]  dbg_state;

    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_sa;
    logic [1:0]  s_a;
    logic [1:0]  s_b;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [4:0]  s_mul;
    logic [1:0]  s_dbg_state;

    int          tests = 0;
    int          fails = 0;
    logic [16:0] exp_q[$];
    logic [16:0] last_mul;

    always #5 clk = ~clk;

    mult_iter #(.A_W(8), .B_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .as(sa), .a(a_in), .b(b_in), .out_valid(out_valid),
        .out_ready(out_ready), .mul(mul), .dbg_state(dbg_state)
    );

    mult_iter #(.A_W(2), .B_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .as(s_sa), .a(s_a), .b(s_b), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .mul(s_mul), .dbg_state(s_dbg_state)
    );

    // Reference: signed value of {s,a} times unsigned b, truncated to 17 bits.
    function automatic logic [16:0] ref_mul(input logic s, input logic [7:0] av, input logic [7:0] bv);
        int v;
        v = (s ? (int'(av) - 256) : int'(av)) * int'(bv);
        return v[16:0];
    endfunction

    function automatic int ref_busy(input logic [7:0] bv);
        int n;
        n = 1;
        for (int i = 0; i < 8; i++) if (bv[i]) n = i + 1;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands until the transfer edge, then scramble the pins.
    task automatic start_txn(input logic s, input logic [7:0] av, input logic [7:0] bv);
        @(posedge clk); #1;
        in_valid = 1'b1; sa = s; a_in = av; b_in = bv;
        @(negedge clk);
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; sa = 1'($urandom); a_in = 8'($urandom); b_in = 8'($urandom);
    endtask

    // Counts BUSY negedges until out_valid; first BUSY cycle also checks mul hold.
    task automatic wait_done(output int cyc);
        cyc = 0;
        @(negedge clk);
        check("mul_hold_busy", 32'(mul), 32'(last_mul));
        while (!out_valid && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check("done_seen", 32'(out_valid), 32'd1);
    endtask

    task automatic run_txn(input logic s, input logic [7:0] av, input logic [7:0] bv, input int hold);
        logic [16:0] exp;
        int          cyc;
        exp = ref_mul(s, av, bv);
        start_txn(s, av, bv);
        wait_done(cyc);
        check("busy_cycles", 32'(cyc), 32'(ref_busy(bv)));
        check("product", 32'(mul), 32'(exp));
        check("ready_in_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            sa = 1'($urandom); a_in = 8'($urandom); b_in = 8'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_mul", 32'(mul), 32'(exp));
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        // Release with in_valid high: the DONE->IDLE edge must not also accept.
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd1);
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_mul", 32'(mul), 32'(exp));
        last_mul = exp;
    endtask

    initial begin
        int          cyc;
        int          sent;
        logic [7:0]  mask;
        int          n_rand;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sa = 1'b0; a_in = '0; b_in = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_sa = 1'b0; s_a = '0; s_b = '0;
        last_mul = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mul", 32'(mul), 32'd0);

        // 2x2 instance: (-3) * 3 = -9 after 2 BUSY cycles.
        @(posedge clk); #1;
        s_in_valid = 1'b1; s_sa = 1'b1; s_a = 2'b01; s_b = 2'b11;
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_b = 2'b00;
        cyc = 0;
        @(negedge clk);
        while (!s_out_valid && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        check("small_busy", 32'(cyc), 32'd2);
        check("small_mul", 32'(s_mul), 32'(5'b10111));
        @(posedge clk); #1 s_out_ready = 1'b1;
        @(posedge clk); #1 s_out_ready = 1'b0;
        @(negedge clk);
        check("small_idle", 32'(s_in_ready), 32'd1);

        // Extremes and early-termination lengths.
        run_txn(1'b1, 8'h00, 8'hFF, 0);
        check("neg_extreme", 32'(last_mul), 32'h10100);
        run_txn(1'b0, 8'hFF, 8'hFF, 0);
        run_txn(1'b0, 8'h05, 8'h00, 0);
        run_txn(1'b0, 8'h05, 8'h01, 0);
        run_txn(1'b0, 8'h05, 8'h80, 0);
        run_txn(1'b1, 8'h7B, 8'h2C, 0);

        // Backpressure in DONE with noisy inputs.
        run_txn(1'b1, 8'hC3, 8'h9A, 10);

        // Reset during the 3rd BUSY cycle of b=0xFF.
        start_txn(1'b0, 8'h33, 8'hFF);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_mul", 32'(mul), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        last_mul = '0;
        run_txn(1'b0, 8'h33, 8'hFF, 0);

        // Random traffic with random valid/ready against the scoreboard.
        n_rand = 3000;
        sent = 0;
        for (int t = 0; t < 60000 && (sent < n_rand || exp_q.size() > 0); t++) begin
            @(posedge clk); #1;
            case ($urandom_range(0, 2))
                0: mask = 8'hFF;
                1: mask = 8'h0F;
                default: mask = 8'h03;
            endcase
            in_valid  = (sent < n_rand) && ($urandom_range(0, 3) != 0);
            sa        = 1'($urandom);
            a_in      = 8'($urandom);
            b_in      = 8'($urandom) & mask;
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_mul(sa, a_in, b_in));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else check("rand_mul", 32'(mul), 32'(exp_q.pop_front()));
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("rand_sent", 32'(sent), 32'(n_rand));
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
